// File: rtl/apb_wait_regfile.sv
// APB slave register file with a programmable number of wait states per transfer.
// Optional macro APB_WAIT_REGFILE_ERR_EN: when defined, pslverr reports bad accesses; otherwise it stays 0.
module apb_wait_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    // state    | meaning
    // S_IDLE   | no transfer; a setup cycle (psel & !penable) captures the request
    // S_WAIT   | counting down inserted wait states, pready low
    // S_ACCESS | pready high for one cycle; writes commit on the edge leaving it

    localparam int IDX_W = $clog2(NUM_REGS);

`ifdef APB_WAIT_REGFILE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t                state;
    logic [3:0]            cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  setup;
    logic [IDX_W-1:0]      idx_in;
    logic                  err_in;
    logic [DATA_WIDTH-1:0] rd_in;
    logic [DATA_WIDTH-1:0] rd_q;

    assign setup  = psel & ~penable;
    assign idx_in = paddr[IDX_W+1:2];
    // Any set bit above the index field means the word index is past the last register.
    assign err_in = (paddr[1:0] != 2'b00)
                  | (|paddr[ADDR_WIDTH-1:IDX_W+2])
                  | (pwrite & (idx_in == '0));

    always_comb begin
        rd_in = '0;
        if (!pwrite && !err_in)
            rd_in = (idx_in == '0) ? ID_VALUE : regs[idx_in];
    end

    always_comb begin
        rd_q = '0;
        if (!write_q && !err_q)
            rd_q = (idx_q == '0) ? ID_VALUE : regs[idx_q];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (setup) begin
                        idx_q   <= idx_in;
                        write_q <= pwrite;
                        err_q   <= err_in;
                        wdata_q <= pwdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                        end else begin
                            // No wait states: present the response straight from the setup inputs.
                            state   <= S_ACCESS;
                            pready  <= 1'b1;
                            pslverr <= ERR_EN & err_in;
                            prdata  <= rd_in;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state   <= S_ACCESS;
                            pready  <= 1'b1;
                            pslverr <= ERR_EN & err_q;
                            prdata  <= rd_q;
                        end
                    end
                end
                S_ACCESS: begin
                    state   <= S_IDLE;
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (psel && write_q && !err_q)
                        regs[idx_q] <= wdata_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Self-checking bench for apb_wait_regfile: two instances (1 and 3 wait states)
// checked against an array-based register model.
module tb_apb_wait_regfile;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        psel1, psel3, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata1, prdata3;
    logic        pready1, pready3, pslverr1, pslverr3;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];

    always #5 hclk = ~hclk;

    apb_wait_regfile #(.WAIT_CYCLES(1)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    apb_wait_regfile #(.WAIT_CYCLES(3)) dut3 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    function automatic logic exp_err(input logic wr, input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (a[1:0] != 2'b00) || (w >= 32'd16) || (wr && (w == 32'd0));
    endfunction

    function automatic logic exp_slv(input logic e);
`ifdef APB_WAIT_REGFILE_ERR_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    function automatic logic [31:0] model_read(input int inst, input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (exp_err(1'b0, a)) return 32'h0;
        if (w == 0) return ID;
        return (inst == 1) ? mem1[w[3:0]] : mem3[w[3:0]];
    endfunction

    task automatic model_write(input int inst, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        w = a >> 2;
        if (!exp_err(1'b1, a)) begin
            if (inst == 1) mem1[w[3:0]] = d;
            else           mem3[w[3:0]] = d;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
    endtask

    task automatic bus_idle();
        @(negedge hclk);
        psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // One APB transfer; returns once pready is seen (bus left in access phase).
    task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        @(negedge hclk);
        psel1 = (inst == 1); psel3 = (inst == 3);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        lat = -1; rdata = 'x; err = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge hclk);
            penable = 1'b1;
            if ((inst == 1) ? pready1 : pready3) begin
                lat   = k;
                rdata = (inst == 1) ? prdata1 : prdata3;
                err   = (inst == 1) ? pslverr1 : pslverr3;
                break;
            end
            pwdata = $urandom();
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL timeout: no pready within 40 cycles (inst %0d addr %h)", inst, addr);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (pready1 !== 1'b0 || pready3 !== 1'b0) begin
            errors++; $display("FAIL reset_pready: got %b/%b want 0/0", pready1, pready3);
        end
        checks++;
        if (prdata1 !== 32'h0 || prdata3 !== 32'h0) begin
            errors++; $display("FAIL reset_prdata: got %h/%h want 0", prdata1, prdata3);
        end
        checks++;
        if (pslverr1 !== 1'b0 || pslverr3 !== 1'b0) begin
            errors++; $display("FAIL reset_pslverr: got %b/%b want 0/0", pslverr1, pslverr3);
        end
    endtask

    task automatic test_id_read();
        logic [31:0] rd; logic e; int lat;
        xfer(1, 1'b0, 32'h0, 32'h0, rd, e, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL id_latency: got %0d want 2", lat); end
        checks++;
        if (rd !== ID) begin errors++; $display("FAIL id_data: got %h want %h", rd, ID); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL id_pslverr: got %b want 0", e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat;
        xfer(1, 1'b1, 32'h4, 32'hDEAD_BEEF, rd, e, lat);
        model_write(1, 32'h4, 32'hDEAD_BEEF);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL b2b_write_err: got %b want 0", e); end
        xfer(1, 1'b0, 32'h4, 32'h0, rd, e, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", lat); end
        checks++;
        if (rd !== model_read(1, 32'h4)) begin
            errors++; $display("FAIL b2b_read: got %h want %h", rd, model_read(1, 32'h4));
        end
        bus_idle();
        checks++;
        if (pready1 !== 1'b0) begin errors++; $display("FAIL b2b_single_ready: got %b want 0", pready1); end
    endtask

    task automatic test_wait3();
        logic [31:0] rd; logic e; int lat;
        xfer(3, 1'b0, 32'h8, 32'h0, rd, e, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wait3_latency: got %0d want 4", lat); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wait3_data: got %h want 0", rd); end
        bus_idle();
        checks++;
        if (pready3 !== 1'b0) begin errors++; $display("FAIL wait3_single_ready: got %b want 0", pready3); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] addrs [3];
        logic        wrs   [3];
        addrs[0] = 32'h00; wrs[0] = 1'b1;
        addrs[1] = 32'h40; wrs[1] = 1'b1;
        addrs[2] = 32'h06; wrs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xfer(1, wrs[i], addrs[i], 32'h1, rd, e, lat);
            checks++;
            if (e !== exp_slv(1'b1)) begin
                errors++; $display("FAIL err_pslverr[%0d]: got %b want %b", i, e, exp_slv(1'b1));
            end
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL err_latency[%0d]: got %0d want 2", i, lat); end
            if (!wrs[i]) begin
                checks++;
                if (rd !== 32'h0) begin errors++; $display("FAIL err_read_data: got %h want 0", rd); end
            end
        end
        xfer(1, 1'b0, 32'h0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== ID) begin errors++; $display("FAIL err_id_kept: got %h want %h", rd, ID); end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic e; int lat;
        @(negedge hclk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h1234_5678;
        @(negedge hclk);
        psel1 = 1'b0; penable = 1'b0;
        @(negedge hclk);
        checks++;
        if (pready1 !== 1'b0 || prdata1 !== 32'h0) begin
            errors++; $display("FAIL abort_outputs: got pready=%b prdata=%h want 0/0", pready1, prdata1);
        end
        xfer(1, 1'b0, 32'hC, 32'h0, rd, e, lat);
        checks++;
        if (rd !== model_read(1, 32'hC)) begin
            errors++; $display("FAIL abort_no_commit: got %h want %h", rd, model_read(1, 32'hC));
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat;
        xfer(1, 1'b1, 32'h10, 32'hFFFF_0000, rd, e, lat);
        hresetn = 1'b0;
        #1;
        checks++;
        if (pready1 !== 1'b0 || prdata1 !== 32'h0 || pslverr1 !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got pready=%b prdata=%h pslverr=%b want 0", pready1, prdata1, pslverr1);
        end
        model_clear();
        @(negedge hclk);
        psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        hresetn = 1'b1;
        xfer(1, 1'b0, 32'h10, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midreset_no_commit: got %h want 0", rd); end
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; logic e, wr; int lat, inst;
        for (int n = 0; n < 80; n++) begin
            inst = ($urandom_range(0, 1) == 0) ? 1 : 3;
            wr   = 1'($urandom_range(0, 1));
            a    = 32'($urandom_range(0, 19)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            d    = $urandom();
            xfer(inst, wr, a, d, rd, e, lat);
            checks++;
            if (lat !== ((inst == 1) ? 2 : 4)) begin
                errors++; $display("FAIL rnd_latency: inst %0d got %0d want %0d", inst, lat, (inst == 1) ? 2 : 4);
            end
            checks++;
            if (e !== exp_slv(exp_err(wr, a))) begin
                errors++; $display("FAIL rnd_pslverr: addr %h wr %b got %b want %b", a, wr, e, exp_slv(exp_err(wr, a)));
            end
            if (wr) begin
                model_write(inst, a, d);
            end else begin
                checks++;
                if (rd !== model_read(inst, a)) begin
                    errors++; $display("FAIL rnd_read: inst %0d addr %h got %h want %h", inst, a, rd, model_read(inst, a));
                end
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();
    endtask

    initial begin
        hresetn = 1'b0;
        psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        model_clear();
        repeat (3) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
        test_reset();
        test_id_read();
        test_back_to_back();
        test_wait3();
        test_errors();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
